// File: rtl/mos6502_pkg.sv
// Shared definitions for the mos6502 timer peripheral: register offsets,
// ctrl bit positions and access-FSM state encoding.
package mos6502_pkg;

    localparam logic [3:0] OFF_T1LO   = 4'h0;
    localparam logic [3:0] OFF_T1HI   = 4'h1;
    localparam logic [3:0] OFF_CTRL   = 4'h2;
    localparam logic [3:0] OFF_STATUS = 4'h3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_IRQEN = 2;
    localparam int CTRL_NMIRT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } acc_state_e;

endpackage

// File: rtl/mos6502_timer_periph_if.sv
// CPU-side bus bundle for the timer peripheral; master = CPU/bench, slave = peripheral.
interface mos6502_timer_periph_if;
    logic [15:0] add_bus;
    logic [7:0]  d_wr;
    logic        write_en;
    logic [7:0]  d_rd;
    logic        d_rd_en;
    logic        rdy;
    logic        irq_n;
    logic        nmi_n;

    modport master (output add_bus, d_wr, write_en,
                    input  d_rd, d_rd_en, rdy, irq_n, nmi_n);
    modport slave  (input  add_bus, d_wr, write_en,
                    output d_rd, d_rd_en, rdy, irq_n, nmi_n);
endinterface

// File: rtl/mos6502_wait_gen.sv
// Access FSM: stretches each selected access by WAIT_STATES cycles via rdy
// and emits a one-cycle commit strobe in the cycle the access completes.
module mos6502_wait_gen
    import mos6502_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sel,
    output logic rdy,
    output logic commit
);

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    acc_state_e state_q, state_d;
    logic [3:0] cnt_w_q, cnt_w_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_w_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_w_q <= cnt_w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_w_d = cnt_w_q;
        case (state_q)
            ST_IDLE: begin
                if (sel && WAIT_STATES != 0) begin
                    state_d = ST_WAIT;
                    cnt_w_d = WS_INIT;
                end
            end
            ST_WAIT: begin
                if (!sel || cnt_w_q == 4'd0) state_d = ST_IDLE;
                else                         cnt_w_d = cnt_w_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset gates the outputs so an aborted access releases the CPU at once.
    always_comb begin
        rdy    = 1'b1;
        commit = 1'b0;
        if (!reset && sel) begin
            case (state_q)
                ST_IDLE: begin
                    if (WAIT_STATES == 0) commit = 1'b1;
                    else                  rdy    = 1'b0;
                end
                ST_WAIT: begin
                    if (cnt_w_q == 4'd0) commit = 1'b1;
                    else                 rdy    = 1'b0;
                end
                default: rdy = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mos6502_timer_periph.sv
// Memory-mapped 16-bit interval timer on the 6502 bus, raising a level IRQ
// or a fixed-width NMI pulse on underflow.
module mos6502_timer_periph
    import mos6502_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int          WAIT_STATES = 1,
    parameter int          PRESCALE    = 1,
    parameter int          NMI_PULSE   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    mos6502_timer_periph_if.slave  bus
);

    localparam logic [7:0]  PRE_MAX  = 8'(PRESCALE - 1);
    localparam logic [15:0] NMI_LAST = 16'(NMI_PULSE - 1);

    logic        sel, commit, wr_commit, rd_commit, tick, underflow;
    logic [3:0]  off;
    logic [7:0]  rd_data;

    logic [15:0] cnt_q, cnt_d, latch_q, latch_d, nmi_cnt_q, nmi_cnt_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  pre_q, pre_d;
    logic        t1_flag_q, t1_flag_d, irq_n_q, irq_n_d, nmi_n_q, nmi_n_d;

    assign sel = (bus.add_bus[15:4] == BASE_ADDR[15:4]);
    assign off = bus.add_bus[3:0];

    mos6502_wait_gen #(.WAIT_STATES(WAIT_STATES)) u_wait_gen (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .rdy    (bus.rdy),
        .commit (commit)
    );

    assign wr_commit = commit & ~bus.write_en;
    assign rd_commit = commit &  bus.write_en;
    assign tick      = ctrl_q[CTRL_EN] && (pre_q == PRE_MAX);
    assign underflow = tick && (cnt_q == 16'd0);

    always_comb begin
        rd_data = 8'h00;
        case (off)
            OFF_T1LO:   rd_data = cnt_q[7:0];
            OFF_T1HI:   rd_data = cnt_q[15:8];
            OFF_CTRL:   rd_data = {4'b0000, ctrl_q};
            OFF_STATUS: rd_data = {~irq_n_q, 6'b000000, t1_flag_q};
            default:    rd_data = 8'h00;
        endcase
    end

    assign bus.d_rd    = rd_commit ? rd_data : 8'h00;
    assign bus.d_rd_en = rd_commit;
    assign bus.irq_n   = irq_n_q;
    assign bus.nmi_n   = nmi_n_q;

    always_comb begin
        cnt_d     = cnt_q;
        latch_d   = latch_q;
        ctrl_d    = ctrl_q;
        t1_flag_d = t1_flag_q;
        pre_d     = 8'd0;
        nmi_cnt_d = nmi_cnt_q;
        nmi_n_d   = 1'b1;

        if (ctrl_q[CTRL_EN]) pre_d = tick ? 8'd0 : pre_q + 8'd1;

        if (tick) begin
            if (cnt_q != 16'd0)        cnt_d = cnt_q - 16'd1;
            else if (ctrl_q[CTRL_CONT]) cnt_d = latch_q;
            else                        cnt_d = 16'd0;
        end
        if (underflow && !ctrl_q[CTRL_CONT]) ctrl_d[CTRL_EN] = 1'b0;

        // Bus writes land after the timer update so they take priority.
        if (wr_commit) begin
            case (off)
                OFF_T1LO: latch_d[7:0] = bus.d_wr;
                OFF_T1HI: begin
                    latch_d[15:8] = bus.d_wr;
                    cnt_d         = {bus.d_wr, latch_q[7:0]};
                    t1_flag_d     = 1'b0;
                    pre_d         = 8'd0;
                end
                OFF_CTRL:   ctrl_d = bus.d_wr[3:0];
                OFF_STATUS: if (bus.d_wr[0]) t1_flag_d = 1'b0;
                default:    ;
            endcase
        end
        if (rd_commit && off == OFF_T1LO) t1_flag_d = 1'b0;
        if (underflow) t1_flag_d = 1'b1;

        if (underflow && ctrl_q[CTRL_NMIRT]) begin
            nmi_cnt_d = NMI_LAST;
            nmi_n_d   = 1'b0;
        end else if (nmi_cnt_q != 16'd0) begin
            nmi_cnt_d = nmi_cnt_q - 16'd1;
            nmi_n_d   = 1'b0;
        end

        irq_n_d = ~(t1_flag_d & ctrl_d[CTRL_IRQEN] & ~ctrl_d[CTRL_NMIRT]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= 16'hFFFF;
            latch_q   <= 16'hFFFF;
            ctrl_q    <= 4'd0;
            t1_flag_q <= 1'b0;
            pre_q     <= 8'd0;
            nmi_cnt_q <= 16'd0;
            irq_n_q   <= 1'b1;
            nmi_n_q   <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            latch_q   <= latch_d;
            ctrl_q    <= ctrl_d;
            t1_flag_q <= t1_flag_d;
            pre_q     <= pre_d;
            nmi_cnt_q <= nmi_cnt_d;
            irq_n_q   <= irq_n_d;
            nmi_n_q   <= nmi_n_d;
        end
    end

endmodule

// File: tb/tb_mos6502_timer_periph.sv
// Directed bench for mos6502_timer_periph: register-map vector table plus
// hand-timed sequences for underflow, IRQ/NMI and reset-abort corners.
module tb_mos6502_timer_periph;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mos6502_timer_periph_if bus_if();

    mos6502_timer_periph #(
        .BASE_ADDR   (16'hD000),
        .WAIT_STATES (1),
        .PRESCALE    (1),
        .NMI_PULSE   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic        exp_en;
        int          exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.add_bus  = 16'h0000;
        bus_if.write_en = 1'b1;
        bus_if.d_wr     = 8'h00;
    endtask

    // Drives one access, returns at commit edge + 1 with the bus idle again.
    task automatic bus_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                              output logic [7:0] rd, output logic rd_en, output int stall);
        @(posedge clk); #1;
        bus_if.add_bus  = a;
        bus_if.write_en = we;
        bus_if.d_wr     = wd;
        stall = 0;
        rd    = 8'h00;
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.rdy) break;
            stall++;
            if (stall > 20) begin
                chk("rdy_timeout", 32'(stall), 32'd0);
                break;
            end
        end
        rd    = bus_if.d_rd;
        rd_en = bus_if.d_rd_en;
        $display("access addr=%h we=%0d wd=%h rd=%h rd_en=%0d stall=%0d", a, we, wd, rd, rd_en, stall);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] rd; logic en; int st;
        bus_access(a, 1'b0, d, rd, en, st);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] rd; logic en; int st;
        bus_access(a, 1'b1, 8'h00, rd, en, st);
        chk(name, {24'd0, rd}, {24'd0, exp});
    endtask

    vec_t vecs[17];
    logic nmi_exp[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [7:0] rd;
        logic       en;
        int         st;

        vecs[0]  = '{16'hD002, 1'b1, 8'h00, 8'h00, 1'b1, 1};
        vecs[1]  = '{16'hD000, 1'b1, 8'h00, 8'hFF, 1'b1, 1};
        vecs[2]  = '{16'hD001, 1'b1, 8'h00, 8'hFF, 1'b1, 1};
        vecs[3]  = '{16'hD003, 1'b1, 8'h00, 8'h00, 1'b1, 1};
        vecs[4]  = '{16'hD00F, 1'b1, 8'h00, 8'h00, 1'b1, 1};
        vecs[5]  = '{16'hD002, 1'b0, 8'h0E, 8'h00, 1'b0, 1};
        vecs[6]  = '{16'hD002, 1'b1, 8'h00, 8'h0E, 1'b1, 1};
        vecs[7]  = '{16'hD002, 1'b0, 8'hF6, 8'h00, 1'b0, 1};
        vecs[8]  = '{16'hD002, 1'b1, 8'h00, 8'h06, 1'b1, 1};
        vecs[9]  = '{16'hD002, 1'b0, 8'h00, 8'h00, 1'b0, 1};
        vecs[10] = '{16'hD005, 1'b0, 8'hAA, 8'h00, 1'b0, 1};
        vecs[11] = '{16'hD005, 1'b1, 8'h00, 8'h00, 1'b1, 1};
        vecs[12] = '{16'hD010, 1'b0, 8'h07, 8'h00, 1'b0, 0};
        vecs[13] = '{16'hCFFF, 1'b0, 8'h07, 8'h00, 1'b0, 0};
        vecs[14] = '{16'hD010, 1'b1, 8'h00, 8'h00, 1'b0, 0};
        vecs[15] = '{16'hCFFF, 1'b1, 8'h00, 8'h00, 1'b0, 0};
        vecs[16] = '{16'hD002, 1'b1, 8'h00, 8'h00, 1'b1, 1};

        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdy",     32'(bus_if.rdy),     32'd1);
        chk("reset_d_rd_en", 32'(bus_if.d_rd_en), 32'd0);
        chk("reset_d_rd",    32'(bus_if.d_rd),    32'd0);
        chk("reset_irq_n",   32'(bus_if.irq_n),   32'd1);
        chk("reset_nmi_n",   32'(bus_if.nmi_n),   32'd1);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            bus_access(vecs[i].addr, vecs[i].we, vecs[i].wd, rd, en, st);
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_rd_en", i), 32'(en), 32'(vecs[i].exp_en));
            if (vecs[i].we) chk($sformatf("vec%0d_rd", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
        end

        // Periodic timer, latch=3, IRQ routed: underflow 4 edges after CTRL commit.
        wr(16'hD000, 8'h03);
        wr(16'hD001, 8'h00);
        wr(16'hD002, 8'h07);
        repeat (3) @(posedge clk);
        #1 chk("t2_irq_before", 32'(bus_if.irq_n), 32'd1);
        @(posedge clk); #1 chk("t2_irq_at_underflow", 32'(bus_if.irq_n), 32'd0);
        bus_access(16'hD000, 1'b1, 8'h00, rd, en, st);
        chk("t2_cnt_after_reload", {24'd0, rd}, 32'h01);
        chk("t2_irq_cleared_by_read", 32'(bus_if.irq_n), 32'd1);
        @(posedge clk); #1 chk("t2_irq_period4", 32'(bus_if.irq_n), 32'd0);

        // STATUS clear landing on the underflow edge must lose to the set.
        @(posedge clk);
        wr(16'hD003, 8'h01);
        chk("t3_irq_clear_vs_underflow", 32'(bus_if.irq_n), 32'd0);
        wr(16'hD003, 8'h01);
        chk("t3_irq_clear_normal", 32'(bus_if.irq_n), 32'd1);
        @(posedge clk); #1 chk("t3_irq_next_underflow", 32'(bus_if.irq_n), 32'd0);
        rd_chk("t3_status", 16'hD003, 8'h81);
        wr(16'hD002, 8'h00);
        chk("t3_irq_off_after_stop", 32'(bus_if.irq_n), 32'd1);

        // One-shot NMI route: pulse of exactly two cycles, EN self-clears.
        wr(16'hD003, 8'h01);
        wr(16'hD000, 8'h02);
        wr(16'hD001, 8'h00);
        wr(16'hD002, 8'h09);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t4_nmi_edge%0d", i + 1), 32'(bus_if.nmi_n), 32'(nmi_exp[i]));
            chk($sformatf("t4_irq_edge%0d", i + 1), 32'(bus_if.irq_n), 32'd1);
        end
        rd_chk("t4_ctrl", 16'hD002, 8'h08);
        rd_chk("t4_cnt_lo", 16'hD000, 8'h00);

        // Reset during the wait state of a CTRL write aborts it.
        @(posedge clk); #1;
        bus_if.add_bus  = 16'hD002;
        bus_if.write_en = 1'b0;
        bus_if.d_wr     = 8'h01;
        @(negedge clk);
        chk("t5_rdy_in_wait", 32'(bus_if.rdy), 32'd0);
        #1 reset = 1'b1;
        #1 chk("t5_rdy_on_reset", 32'(bus_if.rdy), 32'd1);
        @(posedge clk); #1;
        bus_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        rd_chk("t5_ctrl", 16'hD002, 8'h00);
        rd_chk("t5_cnt_lo", 16'hD000, 8'hFF);
        rd_chk("t5_cnt_hi", 16'hD001, 8'hFF);
        chk("t5_nmi_n", 32'(bus_if.nmi_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
